// File: rtl/ctrl_out_rd_pkg.sv
// Shared types and constants for the output-buffer read controller.
// Bank counts and FIFO depth derive from column count and read latency.
package ctrl_out_rd_pkg;

    localparam int HW_LUT_PE_COLS      = 16;
    localparam int HW_DSP_PE_COLS      = 8;
    localparam int HW_BS_OUT_BUF_DEPTH = 8;
    localparam int HW_BP_OUT_BUF_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_BS,
        RD_BP,
        DRAIN
    } state_e;

    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

    function automatic int bs_banks(input int cols);
        return cols / 8;
    endfunction

    function automatic int bp_banks(input int cols);
        return cols / 4;
    endfunction

endpackage

// File: rtl/ctrl_out_rd_if.sv
// Valid/ready stream carrying output-buffer words toward the DMA.
// last marks the final word of a tile.
interface ctrl_out_rd_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/ctrl_out_rd_fifo.sv
// Show-ahead FIFO between the buffer read pipe and the output stream.
// The head entry is visible combinationally; count drives issue credit.
module ctrl_out_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && (cnt_q != CW'(DEPTH));

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/ctrl_out_rd.sv
// Drains one tile from the BS then BP output buffers onto a valid/ready
// stream, hiding the fixed buffer read latency behind a credit FIFO.
module ctrl_out_rd
    import ctrl_out_rd_pkg::*;
#(
    parameter int BS_COLS          = HW_LUT_PE_COLS,
    parameter int BP_COLS          = HW_DSP_PE_COLS,
    parameter int BS_OUT_BUF_DEPTH = HW_BS_OUT_BUF_DEPTH,
    parameter int BP_OUT_BUF_DEPTH = HW_BP_OUT_BUF_DEPTH,
    parameter int DATA_W           = 64,
    parameter int RD_LAT           = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [15:0]                          bs_rd_times,
    input  logic [15:0]                          bp_rd_times,
    input  logic                                 rd_tile_start,
    output logic                                 rd_busy,
    output logic [2:0]                           bs_out_buf_rd_en,
    output logic                                 bs_rd_issue,
    output logic [BS_COLS*BS_OUT_BUF_DEPTH-1:0]  bs_out_buf_rd_addr,
    output logic [2:0]                           bp_out_buf_rd_en,
    output logic                                 bp_rd_issue,
    output logic [BP_COLS*BP_OUT_BUF_DEPTH-1:0]  bp_out_buf_rd_addr,
    input  logic [DATA_W-1:0]                    bs_rd_data,
    input  logic [DATA_W-1:0]                    bp_rd_data,
    ctrl_out_rd_if.master                        m,
    output logic                                 rd_bs_bp_sel,
    output logic                                 rd_tile_end
);
    localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0] BS_BANK_LAST = 3'(bs_banks(BS_COLS) - 1);
    localparam logic [2:0] BP_BANK_LAST = 3'(bp_banks(BP_COLS) - 1);

    state_e            state_q, state_d;
    logic [15:0]       bs_times_q, bp_times_q;
    logic [15:0]       beat_q, beat_d;
    logic [2:0]        bank_q, bank_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_bp_q, tag_last_q;
    logic [CW-1:0]     fifo_cnt;
    logic [CW-1:0]     inflight;
    logic [DATA_W:0]   head;
    logic [DATA_W:0]   push_word;
    logic              credit_ok;
    logic              issue;
    logic              issue_bp;
    logic              beat_final;
    logic              issue_last;
    logic              start_ok;
    logic              hs;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(tag_vld_q[i]);
        end
    end

    // Everything issued but not yet accepted must fit in the FIFO.
    assign credit_ok  = (inflight + fifo_cnt) < CW'(FIFO_DEPTH);
    assign issue_bp   = (state_q == RD_BP);
    assign issue      = credit_ok && ((state_q == RD_BS) || issue_bp);
    assign beat_final = beat_q == ((issue_bp ? bp_times_q : bs_times_q) - 16'd1);
    assign issue_last = beat_final && (issue_bp || (bp_times_q == 16'd0));
    assign start_ok   = (state_q == IDLE) && rd_tile_start;
    assign hs         = m.valid && m.ready;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        bank_d  = bank_q;
        case (state_q)
            IDLE: begin
                if (rd_tile_start) begin
                    if (bs_rd_times != 16'd0) begin
                        state_d = RD_BS;
                    end else if (bp_rd_times != 16'd0) begin
                        state_d = RD_BP;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            RD_BS, RD_BP: begin
                if (issue && beat_final) begin
                    beat_d  = '0;
                    bank_d  = '0;
                    state_d = (!issue_bp && bp_times_q != 16'd0) ? RD_BP : DRAIN;
                end else if (issue) begin
                    beat_d = beat_q + 16'd1;
                    if (bank_q == (issue_bp ? BP_BANK_LAST : BS_BANK_LAST)) begin
                        bank_d = '0;
                    end else begin
                        bank_d = bank_q + 3'd1;
                    end
                end
            end
            DRAIN: begin
                if (rd_tile_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            bank_q     <= '0;
            bs_times_q <= '0;
            bp_times_q <= '0;
            tag_vld_q  <= '0;
            tag_bp_q   <= '0;
            tag_last_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            bank_q     <= bank_d;
            if (start_ok) begin
                bs_times_q <= bs_rd_times;
                bp_times_q <= bp_rd_times;
            end
            tag_vld_q  <= RD_LAT'({tag_vld_q, issue});
            tag_bp_q   <= RD_LAT'({tag_bp_q, issue_bp});
            tag_last_q <= RD_LAT'({tag_last_q, issue_last});
        end
    end

    assign push_word = {tag_last_q[RD_LAT-1],
                        tag_bp_q[RD_LAT-1] ? bp_rd_data : bs_rd_data};

    ctrl_out_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (tag_vld_q[RD_LAT-1]),
        .push_data_i (push_word),
        .pop_i       (hs),
        .head_o      (head),
        .count_o     (fifo_cnt)
    );

    assign m.valid = (fifo_cnt != '0);
    assign m.data  = m.valid ? head[DATA_W-1:0] : '0;
    assign m.last  = m.valid && head[DATA_W];

    // An empty tile ends on entry to DRAIN; otherwise on the last handshake.
    assign rd_tile_end = (state_q == DRAIN) && (inflight == '0) &&
                         (((bs_times_q == 16'd0) && (bp_times_q == 16'd0)) ||
                          (hs && head[DATA_W]));

    assign rd_busy      = (state_q != IDLE);
    assign rd_bs_bp_sel = (state_q == RD_BS);
    assign bs_rd_issue  = issue && !issue_bp;
    assign bp_rd_issue  = issue && issue_bp;

    assign bs_out_buf_rd_en   = (state_q == RD_BS) ? bank_q : '0;
    assign bp_out_buf_rd_en   = (state_q == RD_BP) ? bank_q : '0;
    assign bs_out_buf_rd_addr = (state_q == RD_BS) ?
                                {BS_COLS{beat_q[BS_OUT_BUF_DEPTH-1:0]}} : '0;
    assign bp_out_buf_rd_addr = (state_q == RD_BP) ?
                                {BP_COLS{beat_q[BP_OUT_BUF_DEPTH-1:0]}} : '0;

endmodule

// File: doc/ctrl_out_rd.md
# ctrl_out_rd

Read-side controller for the output buffers filled by the write-back controller. On `rd_tile_start` it drains one tile: the bit-serial (BS) output buffer first, then the bit-parallel (BP) output buffer. It issues buffer reads with the same bank-rotation and address sequence the write-back side used, absorbs the fixed BRAM read latency in a small credit-controlled FIFO, and presents the words on a valid/ready stream toward the output DMA.

## Interface
- `BS_COLS`, default `HW_LUT_PE_COLS`: BS columns. BS bank count = BS_COLS/8.
- `BP_COLS`, default `HW_DSP_PE_COLS`: BP columns. BP bank count = BP_COLS/4.
- `BS_OUT_BUF_DEPTH`, default `HW_BS_OUT_BUF_DEPTH`: BS address width.
- `BP_OUT_BUF_DEPTH`, default `HW_BP_OUT_BUF_DEPTH`: BP address width.
- `DATA_W`, default 64: stream word width.
- `RD_LAT`, default 2: buffer read latency in cycles, issue to data.

Reset is `rst_n`: synchronous, active-low. Clock is `clk`.

- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `bs_rd_times` in 16: BS words per tile. Latched on `rd_tile_start`.
- `bp_rd_times` in 16: BP words per tile. Latched on `rd_tile_start`.
- `rd_tile_start` in 1: start pulse. Ignored while `rd_busy`.
- `rd_busy` out 1: high from the cycle after accepted start through the `rd_tile_end` cycle.
- `bs_out_buf_rd_en` out 3: BS bank select; the read strobe is `bs_rd_issue`.
- `bs_rd_issue` out 1: BS read strobe.
- `bs_out_buf_rd_addr` out BS_COLS×BS_OUT_BUF_DEPTH: BS read address, broadcast to all columns.
- `bp_out_buf_rd_en` out 3: BP bank select.
- `bp_rd_issue` out 1: BP read strobe.
- `bp_out_buf_rd_addr` out BP_COLS×BP_OUT_BUF_DEPTH: BP read address, broadcast to all columns.
- `bs_rd_data` in DATA_W: BS read data, valid RD_LAT cycles after `bs_rd_issue`.
- `bp_rd_data` in DATA_W: BP read data, valid RD_LAT cycles after `bp_rd_issue`.
- `m_data` out DATA_W: stream data.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `m_last` out 1: marks the final word of the tile.
- `rd_bs_bp_sel` out 1: 1 while issuing BS reads, 0 otherwise.
- `rd_tile_end` out 1: one-cycle pulse on the final stream handshake.

## Operation
- States: IDLE, RD_BS, RD_BP, DRAIN.
- IDLE exits on `rd_tile_start`:
  - to RD_BS if bs_times≠0;
  - else to RD_BP if bp_times≠0;
  - else to DRAIN with zero beats, which produces a `rd_tile_end` pulse with no stream traffic.
- RD_BS:
  - One issue per cycle while credit is available.
  - Beat k (0..bs_times-1) reads address k, bank k mod (BS_COLS/8).
  - After the issue of beat bs_times-1: go to RD_BP if bp_times≠0, else DRAIN.
- RD_BP: same rule with bp_times and bank k mod (BP_COLS/4). After the final issue, go to DRAIN.
- DRAIN: wait until the FIFO and the in-flight pipe are empty and the last word has been accepted. Then pulse `rd_tile_end` and return to IDLE.
- Credit rule: issue only if inflight + fifo_count < FIFO_DEPTH, where FIFO_DEPTH = RD_LAT+2. Overflow is therefore impossible.
- Tag pipe: an RD_LAT-deep shift register carries {valid, is_bp, is_last} per issue. Returning data is muxed by is_bp and pushed into the FIFO with is_last.
- `m_last` is the is_last of the FIFO head. is_last is set on:
  - the final BP beat; or
  - the final BS beat when bp_times=0.
- Counter arithmetic:
  - 16-bit beat counters; compare against times-1.
  - Bank counters wrap at the bank count.
  - Addresses are the beat counter truncated to the buffer depth width.
- Stream rule: `m_data`, `m_valid` and `m_last` hold stable while `m_valid & ~m_ready`.
- Reset values (reset mid-tile aborts immediately; in-flight data is discarded):
  - state IDLE;
  - all counters 0;
  - all outputs 0;
  - FIFO and tag pipe cleared.

## Timing
- `rd_tile_start` in cycle t → first issue in cycle t+1.
- Issue in cycle i → FIFO push in cycle i+RD_LAT → `m_valid` in cycle i+RD_LAT+1.
- With `m_ready` held high: sustained 1 word/cycle. First word at t+RD_LAT+2. Last handshake at t+RD_LAT+1+bs_times+bp_times.
- The BS→BP switch inserts no bubble: the BP first issue occurs the cycle after the BS last issue.
- A `rd_tile_start` that coincides with the `rd_tile_end` cycle is ignored. The next start is accepted from the IDLE cycle onward.
- `rd_busy` rises at t+1.

## Structure
- Shared package (`def.sv`): state enum, FIFO_DEPTH = RD_LAT+2, and the BS/BP bank count constants (BS_COLS/8, BP_COLS/4).
- One sub-module, `ctrl_out_rd_fifo`: synchronous show-ahead FIFO, depth FIFO_DEPTH, width DATA_W+1, with a count output.

## Test plan
1. BS_COLS=16, BP_COLS=8, bs=5, bp=3, `m_ready`=1:
   - BS banks 0,1,0,1,0 at addr 0..4;
   - BP banks 0,1,0 at addr 0..2;
   - 8 words in order; `m_last` on word 8;
   - `rd_tile_end` at t+RD_LAT+9.
2. Same tile, `m_ready` toggling 1010…:
   - no word lost or duplicated;
   - issues stall once FIFO_DEPTH words are outstanding;
   - data stable under backpressure.
3. bs=0, bp=2 → no BS issues, 2 words, `m_last` on word 2. bs=3, bp=0 → `m_last` on word 3.
4. bs=0, bp=0 → `rd_tile_end` pulses with zero handshakes; `m_valid` never rises.
5. Second `rd_tile_start` during busy → ignored. `rd_busy` stays high for exactly one tile; the output count is unchanged.
6. `rst_n` low mid-tile (after 2 words) → next cycle all outputs 0 and state IDLE. A new tile then streams cleanly from addr 0.
